// File: rtl/cdbus_pkg.sv
// Shared definitions for the fractional baud generator: width limit,
// generator state encoding and the phase bit-reversal helper.
package cdbus_pkg;

  localparam int unsigned FRAC_W_MAX = 4;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // Reverse the low w bits of v; bits at and above w must be zero on entry.
  function automatic logic [FRAC_W_MAX-1:0] bitrev(
    input logic [FRAC_W_MAX-1:0] v,
    input int unsigned           w
  );
    logic [FRAC_W_MAX-1:0] rev;
    rev = {<<{v}};
    return rev >> (FRAC_W_MAX - w);
  endfunction

endpackage

// File: rtl/baud_frac_gen_if.sv
// Control/status bundle of the fractional baud generator.
interface baud_frac_gen_if #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 2
);

  logic              en;
  logic              sync;
  logic [DIV_W-1:0]  div_ls;
  logic [DIV_W-1:0]  div_hs;
  logic              sel;
  logic [FRAC_W-1:0] cnt;
  logic              inc;
  logic              bit_tick;
  logic              sel_act;

  modport master (
    output en, sync, div_ls, div_hs, sel,
    input  cnt, inc, bit_tick, sel_act
  );

  modport slave (
    input  en, sync, div_ls, div_hs, sel,
    output cnt, inc, bit_tick, sel_act
  );

endinterface

// File: rtl/baud_frac_interp.sv
// Extra-cycle decode: a phase is one cycle longer when its bit-reversed
// index is below the divisor fraction, spreading the extra cycles evenly.
module baud_frac_interp
  import cdbus_pkg::*;
#(
  parameter int unsigned FRAC_W = 2
) (
  input  logic [FRAC_W-1:0] frac_i,
  input  logic [FRAC_W-1:0] phase_i,
  output logic              extend_o
);

  logic [FRAC_W_MAX-1:0] phase_ext;
  logic [FRAC_W_MAX-1:0] phase_rev;

  always_comb begin
    phase_ext               = '0;
    phase_ext[FRAC_W-1:0]   = phase_i;
    phase_rev               = bitrev(phase_ext, FRAC_W);
    extend_o                = (phase_rev[FRAC_W-1:0] < frac_i);
  end

endmodule

// File: rtl/baud_frac_gen.sv
// Fractional baud generator: 2^FRAC_W phases per bit, each M+1 or M+2
// cycles long, so one bit lasts exactly D + 2^FRAC_W cycles.
module baud_frac_gen
  import cdbus_pkg::*;
#(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 2
) (
  input logic            clk,
  input logic            rst,
  baud_frac_gen_if.slave bus
);

  localparam int unsigned MW = DIV_W - FRAC_W;
  localparam int unsigned PW = MW + 1;
  localparam logic [FRAC_W-1:0] CNT_MAX = '1;

  state_e            state_q;
  logic [DIV_W-1:0]  div_q;
  logic              sel_q;
  logic [PW-1:0]     ph_q;
  logic [FRAC_W-1:0] cnt_q;
  logic              inc_q;
  logic              tick_q;

  logic [DIV_W-1:0]  div_d;
  logic              sel_d;
  logic              extend;
  logic [PW-1:0]     term;
  logic              at_term;

  assign sel_d = bus.sel;
  assign div_d = bus.sel ? bus.div_hs : bus.div_ls;

  baud_frac_interp #(
    .FRAC_W (FRAC_W)
  ) u_interp (
    .frac_i   (div_q[FRAC_W-1:0]),
    .phase_i  (cnt_q),
    .extend_o (extend)
  );

  // Terminal count is (M+1)-1 or (M+2)-1; one extra bit keeps M+1 from wrapping.
  assign term    = {1'b0, div_q[DIV_W-1:FRAC_W]} + PW'(extend);
  assign at_term = (ph_q == term);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= bus.div_ls;
      sel_q   <= 1'b0;
      ph_q    <= '0;
      cnt_q   <= '0;
      inc_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      inc_q  <= 1'b0;
      tick_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          ph_q  <= '0;
          cnt_q <= '0;
          div_q <= div_d;
          sel_q <= sel_d;
          if (bus.en) state_q <= RUN;
        end
        RUN: begin
          if (!bus.en) begin
            state_q <= IDLE;
            ph_q    <= '0;
            cnt_q   <= '0;
            div_q   <= div_d;
            sel_q   <= sel_d;
          end else if (bus.sync) begin
            // Restart takes priority over a coincident terminal count.
            ph_q  <= '0;
            cnt_q <= '0;
            div_q <= div_d;
            sel_q <= sel_d;
          end else if (at_term) begin
            ph_q  <= '0;
            cnt_q <= cnt_q + FRAC_W'(1);
            inc_q <= 1'b1;
            if (cnt_q == CNT_MAX) begin
              tick_q <= 1'b1;
              div_q  <= div_d;
              sel_q  <= sel_d;
            end
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.inc      = inc_q;
  assign bus.bit_tick = tick_q;
  assign bus.sel_act  = sel_q;

endmodule

// File: doc/baud_frac_gen.md
BAUD_FRAC_GEN -- requirements
Module: baud_frac_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16, meaning divisor width (8..24).
REQ-002 SHALL have parameter FRAC_W, default 2, meaning fraction bits and log2 of phases per bit (1..4).
REQ-003 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  in  1  run enable; low holds the generator idle.
REQ-006 SHALL have port sync  in  1  restart the bit timing from phase 0.
REQ-007 SHALL have port div_ls  in  DIV_W  low-speed divisor {mantissa, fraction}; full range allowed.
REQ-008 SHALL have port div_hs  in  DIV_W  high-speed divisor, same format.
REQ-009 SHALL have port sel  in  1  1 = high speed, 0 = low speed.
REQ-010 SHALL have port cnt  out  FRAC_W  current phase index within the bit.
REQ-011 SHALL have port inc  out  1  one-cycle pulse at each phase end.
REQ-012 SHALL have port bit_tick  out  1  one-cycle pulse when cnt wraps from max to 0.
REQ-013 SHALL have port sel_act  out  1  speed select currently in effect.

Function
REQ-014 SHALL split the latched divisor D as M = D[DIV_W-1:FRAC_W] and f = D[FRAC_W-1:0].
REQ-015 SHALL make the length of phase i equal to M+2 cycles if bitrev_FRAC_W(i) < f, and M+1 cycles otherwise.
REQ-016 SHALL compute M+1 one bit wider than M, so no divisor value overflows.
REQ-017 SHALL make one bit period exactly D + 2^FRAC_W cycles.
REQ-018 SHALL have two states: IDLE and RUN.
REQ-019 SHALL go IDLE->RUN when en=1, and RUN->IDLE when en=0, with effect on the next edge.
REQ-020 In IDLE: phase counter, cnt, inc and bit_tick SHALL be held at 0; divisor and sel SHALL be re-latched every cycle.
REQ-021 On entering RUN, phase 0 SHALL start with the divisor latched in the last IDLE cycle.
REQ-022 The phase counter SHALL increment every RUN cycle.
REQ-023 When the phase counter equals its terminal value (length-1), the counter SHALL clear, cnt SHALL increment modulo 2^FRAC_W, and inc SHALL assert on that same edge (registered, 1 cycle).
REQ-024 bit_tick SHALL assert together with inc only when cnt goes from 2^FRAC_W-1 to 0.
REQ-025 div_ls, div_hs and sel SHALL be sampled only on the bit_tick edge, on sync, or in IDLE.
REQ-026 Input changes mid-bit SHALL take effect from the next phase 0; sel_act SHALL reflect the latched sel.
REQ-027 sync=1 in RUN SHALL clear the phase counter and cnt, force inc=bit_tick=0, and re-latch divisor and sel.
REQ-028 If sync coincides with a terminal count, sync SHALL win and no inc SHALL be issued.
REQ-029 sync in IDLE SHALL have no effect beyond REQ-020.
REQ-030 With D < 2^FRAC_W (M=0, f=0 case included), inc SHALL pulse every cycle or every second cycle per REQ-015, with no gaps or stalls.

Reset
REQ-031 rst SHALL override en and sync.
REQ-032 On rst: state=IDLE and cnt, inc, bit_tick, phase counter = 0.
REQ-033 On rst: latched divisor = div_ls and sel_act = 0.
REQ-034 rst asserted mid-bit SHALL abort the bit with no trailing inc or bit_tick pulse.

Structure
REQ-035 The shared package cdbus_pkg SHALL hold the FRAC_W_MAX=4 constant, the state enum {IDLE, RUN}, and the bit-reverse function.
REQ-036 The extra-cycle mask decode (f, phase -> extend) SHALL be one combinational sub-module, baud_frac_interp.
REQ-037 Everything else SHALL live in baud_frac_gen.

Verification
REQ-038 FRAC_W=2, div_ls=0x0010, en=1 -> inc every 5 cycles, bit_tick every 20 cycles.
REQ-039 FRAC_W=2, div=0x0013 -> phase lengths 6,6,6,5 for cnt 0..3, bit period 23 cycles; f=1 -> 6,5,5,5; f=2 -> 6,5,6,5.
REQ-040 FRAC_W=3, div=0x0025 -> phases 0,1,2,4,6 last 6 cycles and phases 3,5,7 last 5 cycles, bit period 45 cycles.
REQ-041 div_ls=0x0010, div_hs=0x0008, sel toggled at cnt=1 -> current bit finishes at 20 cycles; the next bit takes 12 cycles; sel_act changes on the bit_tick edge.
REQ-042 sync asserted on the terminal-count cycle -> no inc; next inc M+1 cycles later with cnt=1.
REQ-043 rst and en=0 each asserted mid-phase -> all outputs 0 the next cycle; after release, the first inc comes a full phase length later.
